// File: rtl/fta_bus_pkg.sv
// FTA bus transaction types shared by every master and slave on the bus.
package fta_bus_pkg;

  typedef enum logic [4:0] {
    CMD_NONE        = 5'd0,
    CMD_LOAD        = 5'd2,
    CMD_LOADZ       = 5'd3,
    CMD_STORE       = 5'd4,
    CMD_ICACHE_LOAD = 5'd12
  } fta_cmd_t;

  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [3:0] tranid;
  } fta_tranid_t;

  typedef struct packed {
    fta_cmd_t     cmd;
    fta_tranid_t  tid;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  padr;
    logic [127:0] dat;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_tranid_t  tid;
    logic         ack;
    logic         rty;
    logic [127:0] dat;
  } fta_cmd_response128_t;

endpackage

// File: rtl/rf80386_pkg.sv
// Shared state and access-size definitions for the rf80386 bus sequencer.
package rf80386_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    ISSUE2,
    WAIT2,
    DONE
  } e_bus_seq_state;

  localparam logic [1:0] BSZ_BYTE  = 2'd0;
  localparam logic [1:0] BSZ_WORD  = 2'd1;
  localparam logic [1:0] BSZ_DWORD = 2'd2;

  // Encoding 3 is reserved and behaves like a dword access.
  function automatic logic [2:0] sizeBytes(input logic [1:0] sz);
    case (sz)
      BSZ_BYTE: return 3'd1;
      BSZ_WORD: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rf80386_byte_lane.sv
// Byte-lane steering for one beat of a CPU access onto a 16-byte bus line.
module rf80386_byte_lane
  import rf80386_pkg::*;
(
  input  logic         beat2_i,
  input  logic [3:0]   ofs_i,
  input  logic [1:0]   size_i,
  input  logic [31:0]  wdat_i,
  input  logic [127:0] bus_dat_i,
  output logic         split_o,
  output logic [15:0]  sel_o,
  output logic [127:0] bus_dat_o,
  output logic [31:0]  rdat_o
);

  logic [2:0] nBytes;
  logic [4:0] firstBytes;
  logic [4:0] secondBytes;

  // Beat 2 carries what did not fit above the offset; its bytes land above beat-1's in rdat.
  always_comb begin
    nBytes      = sizeBytes(size_i);
    firstBytes  = 5'd16 - {1'b0, ofs_i};
    split_o     = ({1'b0, ofs_i} + {2'b00, nBytes}) > 5'd16;
    secondBytes = split_o ? ({2'b00, nBytes} - firstBytes) : 5'd0;
    if (!beat2_i) begin
      sel_o     = (16'hFFFF >> (5'd16 - {2'b00, nBytes})) << ofs_i;
      bus_dat_o = {96'd0, wdat_i} << {ofs_i, 3'b000};
      rdat_o    = 32'(bus_dat_i >> {ofs_i, 3'b000})
                  & (32'hFFFF_FFFF >> {3'd4 - nBytes, 3'b000});
    end else begin
      sel_o     = 16'hFFFF >> (5'd16 - secondBytes);
      bus_dat_o = {96'd0, wdat_i} >> {firstBytes, 3'b000};
      rdat_o    = (bus_dat_i[31:0] & (32'hFFFF_FFFF >> (8'd32 - {secondBytes, 3'b000})))
                  << {firstBytes, 3'b000};
    end
  end

endmodule

// File: rtl/rf80386_bus_sequencer.sv
// Turns one CPU memory access into one or two FTA line beats, with retry and timeout handling.
module rf80386_bus_sequencer
  import rf80386_pkg::*;
  import fta_bus_pkg::*;
#(
  parameter logic [5:0] CORENO  = 6'd1,
  parameter logic [2:0] CID     = 3'd1,
  parameter logic [3:0] RTY_MAX = 4'd15,
  parameter logic [7:0] TMO_MAX = 8'd255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic                 code_i,
  input  logic [1:0]           size_i,
  input  logic [31:0]          adr_i,
  input  logic [31:0]          wdat_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          rdat_o,
  output fta_cmd_request128_t  ftam_req,
  input  fta_cmd_response128_t ftam_resp
);

  e_bus_seq_state state_q;
  logic           we_q, code_q, beat2_q, err_q;
  logic [1:0]     size_q;
  logic [31:0]    adr_q, wdat_q, rdatAcc_q, rdat_q;
  logic [3:0]     tranId_q;
  fta_tranid_t    tid_q;
  logic [4:0]     retryCnt_q;
  logic [7:0]     tmoCnt_q;

  logic           split, issuing, inWait, tidMatch, ackValid, rtyValid;
  logic           retryExhausted, tmoHit, goIssue;
  logic [3:0]     tranIdInc;
  logic [15:0]    laneSel;
  logic [127:0]   laneDat;
  logic [31:0]    laneRdat;

  rf80386_byte_lane uLane (
    .beat2_i   (beat2_q),
    .ofs_i     (adr_q[3:0]),
    .size_i    (size_q),
    .wdat_i    (wdat_q),
    .bus_dat_i (ftam_resp.dat),
    .split_o   (split),
    .sel_o     (laneSel),
    .bus_dat_o (laneDat),
    .rdat_o    (laneRdat)
  );

  // A response only counts when it carries the tid of the beat last issued; rty wins over ack.
  always_comb begin
    issuing        = (state_q == ISSUE1) || (state_q == ISSUE2);
    inWait         = (state_q == WAIT1) || (state_q == WAIT2);
    tidMatch       = ftam_resp.tid == tid_q;
    rtyValid       = ftam_resp.rty && tidMatch;
    ackValid       = ftam_resp.ack && !ftam_resp.rty && tidMatch;
    retryExhausted = (retryCnt_q + 5'd1) > {1'b0, RTY_MAX};
    tmoHit         = ({1'b0, tmoCnt_q} + 9'd1) >= {1'b0, TMO_MAX};
    tranIdInc      = (tranId_q == 4'd15) ? 4'd1 : tranId_q + 4'd1;
    goIssue        = ((state_q == IDLE) && req_i)
                   || (inWait && rtyValid && !retryExhausted)
                   || ((state_q == WAIT1) && ackValid && split);

    ftam_req     = '0;
    ftam_req.tid = tid_q;
    if (issuing) begin
      ftam_req.cmd  = we_q ? CMD_STORE : (code_q ? CMD_ICACHE_LOAD : CMD_LOAD);
      ftam_req.cyc  = 1'b1;
      ftam_req.stb  = 1'b1;
      ftam_req.we   = we_q;
      ftam_req.sel  = laneSel;
      ftam_req.padr = beat2_q ? {adr_q[31:4] + 28'd1, 4'h0} : adr_q;
      ftam_req.dat  = we_q ? laneDat : '0;
    end
  end

  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign err_o  = (state_q == DONE) && err_q;
  assign rdat_o = rdat_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      code_q     <= 1'b0;
      beat2_q    <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'd0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdatAcc_q  <= '0;
      rdat_q     <= '0;
      tranId_q   <= 4'd1;
      tid_q      <= '{core: CORENO, channel: CID, tranid: 4'd1};
      retryCnt_q <= '0;
      tmoCnt_q   <= '0;
    end else begin
      if (goIssue) begin
        tid_q.tranid <= tranId_q;
        tranId_q     <= tranIdInc;
      end
      case (state_q)
        IDLE: if (req_i) begin
          we_q       <= we_i;
          code_q     <= code_i;
          size_q     <= size_i;
          adr_q      <= adr_i;
          wdat_q     <= wdat_i;
          beat2_q    <= 1'b0;
          err_q      <= 1'b0;
          rdatAcc_q  <= '0;
          retryCnt_q <= '0;
          state_q    <= ISSUE1;
        end
        ISSUE1, ISSUE2: begin
          tmoCnt_q <= '0;
          state_q  <= (state_q == ISSUE1) ? WAIT1 : WAIT2;
        end
        WAIT1, WAIT2: begin
          if (rtyValid) begin
            if (retryExhausted) begin
              err_q   <= 1'b1;
              rdat_q  <= '0;
              state_q <= DONE;
            end else begin
              retryCnt_q <= retryCnt_q + 5'd1;
              state_q    <= (state_q == WAIT1) ? ISSUE1 : ISSUE2;
            end
          end else if (ackValid) begin
            if ((state_q == WAIT1) && split) begin
              rdatAcc_q  <= laneRdat;
              beat2_q    <= 1'b1;
              retryCnt_q <= '0;
              state_q    <= ISSUE2;
            end else begin
              rdat_q  <= we_q ? '0 : (rdatAcc_q | laneRdat);
              state_q <= DONE;
            end
          end else if (tmoHit) begin
            err_q   <= 1'b1;
            rdat_q  <= '0;
            state_q <= DONE;
          end else begin
            tmoCnt_q <= tmoCnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf80386_bus_sequencer.sv
// Self-checking bench: table of accesses against a byte-wise memory and bus model, plus reset corner cases.
module tb_rf80386_bus_sequencer;
  import rf80386_pkg::*;
  import fta_bus_pkg::*;

  typedef struct {
    logic        we;
    logic        code;
    logic [1:0]  size;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          rty;
    int          delay;
    bit          stale;
    bit          noAck;
    bit          reqNoise;
    int          expIssues;
    bit          expErr;
  } vec_t;

  typedef struct {
    logic [31:0] rdat;
    bit          err;
    bit          checkRdat;
  } exp_t;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 req_i = 1'b0;
  logic                 we_i = 1'b0;
  logic                 code_i = 1'b0;
  logic [1:0]           size_i = 2'd0;
  logic [31:0]          adr_i = '0;
  logic [31:0]          wdat_i = '0;
  logic                 busy_o, done_o, err_o;
  logic [31:0]          rdat_o;
  fta_cmd_request128_t  ftam_req;
  fta_cmd_response128_t resp;

  exp_t sbQueue[$];
  vec_t vecs[15];
  int   assertCount = 0;
  int   failCount = 0;
  int   expTran = 1;

  rf80386_bus_sequencer dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .we_i      (we_i),
    .code_i    (code_i),
    .size_i    (size_i),
    .adr_i     (adr_i),
    .wdat_i    (wdat_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .rdat_o    (rdat_o),
    .ftam_req  (ftam_req),
    .ftam_resp (resp)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] byteAt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [127:0] lineData(input logic [27:0] line);
    logic [127:0] d;
    d = '0;
    for (int j = 0; j < 16; j++) d[8*j +: 8] = byteAt({line, 4'(j)});
    return d;
  endfunction

  function automatic vec_t mkVec(input logic we, input logic code, input logic [1:0] size,
                                 input logic [31:0] adr, input logic [31:0] wdat, input int rty,
                                 input int delay, input bit stale, input bit noAck,
                                 input bit reqNoise, input int expIssues, input bit expErr);
    vec_t v;
    v.we = we; v.code = code; v.size = size; v.adr = adr; v.wdat = wdat;
    v.rty = rty; v.delay = delay; v.stale = stale; v.noAck = noAck;
    v.reqNoise = reqNoise; v.expIssues = expIssues; v.expErr = expErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic checkResetState(input string tag);
    fta_cmd_request128_t rq;
    rq = '0;
    rq.tid.core = 6'd1;
    rq.tid.channel = 3'd1;
    rq.tid.tranid = 4'd1;
    checkOutput({tag, " busy_o"}, busy_o, 0);
    checkOutput({tag, " done_o"}, done_o, 0);
    checkOutput({tag, " err_o"}, err_o, 0);
    checkOutput({tag, " rdat_o"}, rdat_o, 0);
    checkOutput({tag, " ftam_req"}, ftam_req, rq);
  endtask

  task automatic applyStimulus(input vec_t v);
    int n, cyc, issues, beat, respAt, lastAckAt, rtyLeft;
    bit issueExpected, doneSeen, pending, staleDone, isSplit;
    fta_tranid_t lastTid;
    logic [31:0] a;
    logic [31:0] expPadr;
    logic [15:0] expSel;
    exp_t e, got;
    n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    isSplit = (int'(v.adr[3:0]) + n) > 16;
    e.rdat = '0;
    for (int i = 0; i < n; i++) e.rdat[8*i +: 8] = byteAt(v.adr + 32'(i));
    e.err = v.expErr;
    e.checkRdat = !v.we && !v.expErr;
    sbQueue.push_back(e);

    @(negedge clk_i);
    req_i = 1'b1; we_i = v.we; code_i = v.code; size_i = v.size; adr_i = v.adr; wdat_i = v.wdat;
    cyc = 0; issues = 0; beat = 1; pending = 0; doneSeen = 0; issueExpected = 1;
    rtyLeft = v.rty; staleDone = 0; lastAckAt = -10; respAt = 0;
    lastTid = '0;
    while (!doneSeen && cyc < 600) begin
      @(negedge clk_i);
      cyc++;
      req_i = v.reqNoise;
      resp.ack = 1'b0;
      resp.rty = 1'b0;
      if (done_o) begin
        doneSeen = 1;
        req_i = 1'b0;
        checkOutput("issue count", issues, v.expIssues);
        if (!v.noAck) checkOutput("done latency", cyc, lastAckAt + 1);
        if (sbQueue.size() == 0) begin
          checkOutput("scoreboard entry present", 0, 1);
        end else begin
          got = sbQueue.pop_front();
          checkOutput("err_o", err_o, got.err);
          checkOutput("busy_o in done", busy_o, 1);
          if (got.checkRdat) checkOutput("rdat_o", rdat_o, got.rdat);
        end
      end else if (ftam_req.cyc) begin
        checkOutput("cyc expected", issueExpected, 1);
        if (issues == 0) checkOutput("first cyc latency", cyc, 1);
        issues++;
        issueExpected = 0;
        expSel = '0;
        expPadr = (beat == 1) ? v.adr : {v.adr[31:4] + 28'd1, 4'h0};
        for (int i = 0; i < n; i++) begin
          a = v.adr + 32'(i);
          if (a[31:4] == expPadr[31:4]) begin
            expSel[a[3:0]] = 1'b1;
            if (v.we) checkOutput("write byte", ftam_req.dat[{a[3:0], 3'b000} +: 8], v.wdat[8*i +: 8]);
          end
        end
        checkOutput("stb", ftam_req.stb, 1);
        checkOutput("we", ftam_req.we, v.we);
        checkOutput("sel", ftam_req.sel, expSel);
        checkOutput("padr", ftam_req.padr, expPadr);
        checkOutput("tid core", ftam_req.tid.core, 6'd1);
        checkOutput("tid channel", ftam_req.tid.channel, 3'd1);
        checkOutput("tranid", ftam_req.tid.tranid, expTran);
        expTran = (expTran == 15) ? 1 : expTran + 1;
        lastTid = ftam_req.tid;
        pending = !v.noAck;
        respAt = cyc + v.delay;
      end else begin
        checkOutput("idle strobes", {ftam_req.stb, ftam_req.we, ftam_req.sel}, 0);
        if (pending && cyc == respAt) begin
          resp.tid = lastTid;
          resp.dat = lineData((beat == 1) ? v.adr[31:4] : v.adr[31:4] + 28'd1);
          if (v.stale && !staleDone) begin
            resp.tid.tranid = lastTid.tranid ^ 4'h8;
            resp.ack = 1'b1;
            staleDone = 1;
            respAt = cyc + 2;
          end else if (rtyLeft > 0) begin
            resp.rty = 1'b1;
            resp.ack = (rtyLeft == 2);
            rtyLeft--;
            pending = 0;
            issueExpected = 1;
            lastAckAt = cyc;
          end else begin
            resp.ack = 1'b1;
            pending = 0;
            lastAckAt = cyc;
            if (beat == 1 && isSplit) begin
              beat = 2;
              issueExpected = 1;
            end
          end
        end
      end
    end
    if (!doneSeen) begin
      checkOutput("done within cycle budget", 0, 1);
      void'(sbQueue.pop_front());
    end
    req_i = 1'b0;
    resp.ack = 1'b0;
    resp.rty = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    fta_tranid_t hold;
    resp = '0;
    vecs[0]  = mkVec(0, 0, BSZ_DWORD, 32'h1000_0004, 32'h0,        0, 3, 0, 0, 0, 1, 0);
    vecs[1]  = mkVec(1, 0, BSZ_DWORD, 32'h0000_100E, 32'h4433_2211, 0, 1, 0, 0, 0, 2, 0);
    vecs[2]  = mkVec(0, 1, BSZ_BYTE,  32'h0000_2003, 32'h0,        0, 1, 0, 0, 0, 1, 0);
    vecs[3]  = mkVec(0, 0, BSZ_WORD,  32'h0000_300F, 32'h0,        0, 2, 0, 0, 0, 2, 0);
    vecs[4]  = mkVec(0, 0, BSZ_DWORD, 32'h0000_400C, 32'h0,        0, 1, 0, 0, 0, 1, 0);
    vecs[5]  = mkVec(0, 0, 2'd3,      32'h0000_500D, 32'h0,        0, 2, 0, 0, 0, 2, 0);
    vecs[6]  = mkVec(1, 0, BSZ_BYTE,  32'h0000_600F, 32'h0000_00AB, 0, 1, 0, 0, 0, 1, 0);
    vecs[7]  = mkVec(1, 0, BSZ_WORD,  32'h0000_7006, 32'h0000_BEEF, 2, 1, 0, 0, 0, 3, 0);
    vecs[8]  = mkVec(0, 0, BSZ_DWORD, 32'h0000_800F, 32'h0,        1, 1, 0, 0, 0, 3, 0);
    vecs[9]  = mkVec(0, 0, BSZ_DWORD, 32'h0000_9000, 32'h0,        0, 2, 1, 0, 0, 1, 0);
    vecs[10] = mkVec(0, 0, BSZ_WORD,  32'h0000_A002, 32'h0,        0, 1, 0, 0, 1, 1, 0);
    vecs[11] = mkVec(0, 0, BSZ_DWORD, 32'h0000_0040, 32'h0,       16, 1, 0, 0, 0, 16, 1);
    vecs[12] = mkVec(1, 0, BSZ_DWORD, 32'h0000_B00E, 32'h8877_6655, 16, 1, 0, 0, 0, 16, 1);
    vecs[13] = mkVec(0, 0, BSZ_DWORD, 32'h0000_0100, 32'h0,        0, 1, 0, 1, 0, 1, 1);
    vecs[14] = mkVec(1, 0, BSZ_DWORD, 32'h0000_0208, 32'hCAFE_F00D, 0, 4, 0, 0, 0, 1, 0);

    repeat (3) @(negedge clk_i);
    checkResetState("reset");
    rst_ni = 1'b1;
    expTran = 1;

    for (int k = 0; k < 15; k++) applyStimulus(vecs[k]);

    for (int k = 0; k < 16; k++)
      applyStimulus(mkVec(0, 0, BSZ_BYTE, 32'h0000_D000 + 32'(k), 32'h0, 0, 1, 0, 0, 0, 1, 0));

    $display("[TB] reset during beat 2 of a split read");
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; code_i = 1'b0; size_i = BSZ_DWORD; adr_i = 32'h0000_C00E;
    @(negedge clk_i);
    req_i = 1'b0;
    checkOutput("mid-reset beat1 cyc", ftam_req.cyc, 1);
    checkOutput("mid-reset beat1 tranid", ftam_req.tid.tranid, expTran);
    hold = ftam_req.tid;
    @(negedge clk_i);
    resp.tid = hold; resp.ack = 1'b1; resp.dat = lineData(28'h0000_C00);
    @(negedge clk_i);
    resp.ack = 1'b0;
    checkOutput("mid-reset beat2 cyc", ftam_req.cyc, 1);
    checkOutput("mid-reset beat2 padr", ftam_req.padr, 32'h0000_C010);
    hold = ftam_req.tid;
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    checkResetState("mid-reset");
    resp.tid = hold; resp.ack = 1'b1; resp.dat = lineData(28'h0000_C01);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      resp.ack = 1'b0;
      checkOutput("late ack done_o", done_o, 0);
      checkOutput("late ack busy_o", busy_o, 0);
    end
    expTran = 1;
    applyStimulus(mkVec(0, 0, BSZ_WORD, 32'h0000_E004, 32'h0, 0, 2, 0, 0, 0, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rf80386_bus_sequencer.md
RF80386_BUS_SEQUENCER -- requirements
Module: rf80386_bus_sequencer

Interface
REQ-001 Parameters SHALL be: CORENO, default 6'd1, core number placed in ftam_req.tid.core; CID, default 3'd1, channel in ftam_req.tid.channel; RTY_MAX, default 4'd15, retries allowed per beat; TMO_MAX, default 8'd255, cycles to wait for ack per beat.
REQ-002 Ports SHALL be, in this order (name, direction, width, meaning):
- clk_i  in  1  sole clock, all logic on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  1  access request, sampled only in IDLE.
- we_i  in  1  1 = write, 0 = read.
- code_i  in  1  code fetch; drives ftam_req.cmd to a code-read command instead of a data read.
- size_i  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = reserved (treated as 4).
- adr_i  in  32  linear byte address.
- wdat_i  in  32  write data, little-endian.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  qualifies done_o; high when retry limit or timeout was hit.
- rdat_o  out  32  assembled read data; zero-extended above size_i; valid with done_o.
- ftam_req  out  fta_cmd_request128_t  bus request.
- ftam_resp  in  fta_cmd_response128_t  bus response.

Function
REQ-003 The block SHALL sequence one CPU memory access into one or two 16-byte-line beats on the fta bus.
REQ-004 States SHALL be IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
- IDLE to ISSUE1 on req_i, latching we/code/size/adr/wdat.
- ISSUEn to WAITn always.
- WAIT1 to ISSUE2 on a valid ack when the access is split; otherwise WAIT1 to DONE.
- WAIT2 to DONE on a valid ack.
- DONE to IDLE always.
REQ-005 An access SHALL be split when adr[3:0] + nbytes > 16, where nbytes = 1, 2 or 4.
- Beat 1 sel = ({16{1'b1}} >> (16-nbytes)) << adr[3:0], truncated to 16 bits.
- Beat 2 goes to adr[31:4]+1, line offset 0, and carries the remaining bytes.
REQ-006 In an ISSUE state, ftam_req.cyc and ftam_req.stb SHALL be high for exactly one cycle, with we, sel, padr (line address plus offset), tid and dat valid. ftam_req.cyc, stb, we and sel SHALL be 0 in every other cycle.
REQ-007 Write data SHALL be placed on the 128-bit bus as follows:
- Beat 1: wdat << (adr[3:0]*8).
- Beat 2: wdat >> ((16-adr[3:0])*8).
REQ-008 Read bytes SHALL be gathered as follows:
- Beat 1: ftam_resp.dat >> (adr[3:0]*8).
- Beat 2: its low bytes are appended above the beat-1 bytes.
- rdat_o SHALL hold its value until the next done_o.
REQ-009 A valid ack SHALL be ftam_resp.ack=1 with ftam_resp.tid equal to the last issued tid. An ack with any other tid SHALL be ignored.
REQ-010 ftam_req.tid.tranid SHALL increment on every issue, wrapping 15 to 1 (0 is never used).
REQ-011 Retry handling:
- On ftam_resp.rty with a matching tid in WAITn, the block SHALL return to ISSUEn and increment the beat retry counter.
- ack and rty together SHALL be treated as rty.
- If the counter exceeds RTY_MAX, the block SHALL go to DONE with err_o=1.
REQ-012 The timeout counter SHALL clear on each issue and increment each WAIT cycle. Reaching TMO_MAX SHALL go to DONE with err_o=1 and discard the partial rdat.
REQ-013 done_o and err_o SHALL be asserted only in DONE.
REQ-014 req_i SHALL be ignored outside IDLE. Minimum spacing between accepted requests is therefore 1 cycle after DONE.
REQ-015 Latency: with req_i at cycle 0, beat-1 cyc is at cycle 1. For an unsplit access with ack at cycle k, done_o is at cycle k+1.
REQ-016 On an error, a split write SHALL NOT issue beat 2 after a beat-1 error.

Reset
REQ-017 While rst_ni=0 at a clock edge the block SHALL enter IDLE, regardless of any operation in progress, and outstanding responses SHALL be dropped.
REQ-018 Reset values SHALL be:
- ftam_req all zero except tid.core=CORENO, tid.channel=CID, tid.tranid=1.
- busy_o=0, done_o=0, err_o=0, rdat_o=0.
- Retry and timeout counters = 0.
REQ-019 The first issue after reset SHALL use tranid 1.

Structure
REQ-020 rf80386_pkg SHALL hold the e_bus_seq_state enum and the size encoding constants (BSZ_BYTE, BSZ_WORD, BSZ_DWORD).
REQ-021 Bus types SHALL come from fta_bus_pkg unchanged.
REQ-022 One combinational sub-module, rf80386_byte_lane, SHALL compute sel, the write shift and the read extraction for a given beat, offset and size.

Verification
REQ-023 Single read: size 4, adr 32'h1000_0004, ack after 3 cycles with dat[63:32]=32'hDEADBEEF -> one cyc pulse with sel 16'h00F0; rdat_o=32'hDEADBEEF with done_o, err_o=0.
REQ-024 Split write: size 4, adr 32'h0000_100E, wdat 32'h44332211 ->
- Beat 1: sel 16'hC000, dat[127:112]=16'h2211.
- Beat 2: padr 32'h0000_1010, sel 16'h0003, dat[15:0]=16'h4433.
- done_o once.
REQ-025 Retry then error: read with rty returned RTY_MAX+1 times with matching tid -> RTY_MAX+1 issues, each with a new tranid; then done_o=1 and err_o=1.
REQ-026 Stale ack: an ack with the wrong tid, then a correct ack 2 cycles later -> the first is ignored; done_o follows the second by 1 cycle.
REQ-027 Reset mid-access: rst_ni low in WAIT2 of a split read, then a late ack -> IDLE with all outputs at reset values; the late ack produces no done_o.
REQ-028 Tranid wrap: 16 back-to-back byte reads -> tranid sequence 1..15, then 1.
